pipe_scroller: RTL and testbench
================================

# pipe_scroller

Upstream pipe source for the Flappy 16x16 LED-matrix game. Spawns two pipe obstacles at the right edge of the matrix and scrolls them one column left per game step. Each pipe gets a pseudo-random gap height and gap size. Outputs rendered 16x16 pipe frames plus per-pipe gap geometry, which feed the collision/scoring stage directly.

## Interface
Parameters:
- TICK_DIV, 25_000_000: clock cycles per game step (≥2)
- SPACING, 8: steps between spawns (≥8, so at most two pipes are on screen)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; restores all reset values
- start  in  1  level; leaves IDLE/HALT
- game_over  in  1  level from collision stage; freezes scrolling
- pipe1, pipe2  out  [15:0][15:0]  frame per slot
  - index [r][c]: r = row 0..15, c = column bit
  - bit 15 = leftmost column, bit 0 = rightmost (entry) column
- height1, height2  out  3  gap bottom row of slot 1/2
- size1, size2  out  3  gap row count of slot 1/2 (3..6 when active)
- at_left1, at_left2  out  1  one-cycle pulse when the slot's pipe enters column 15
- running  out  1  high in RUN

## Operation
- FSM states IDLE, RUN, HALT.
  - IDLE → RUN on start.
  - RUN → HALT on game_over.
  - HALT → RUN on start, and start also clears both slots. game_over has priority over start.
- Slot state (×2): active, col[3:0], height[2:0], size[2:0]. Inactive slot renders an all-zero frame and outputs height = size = 0.
- Rendering (combinational from slot registers):
  - pipeN[r][c] = 1 iff active, c == col, and r ∉ [height, height+size-1].
  - Max gap top is 7 + 6 − 1 = 12, so there is no overflow.
- Step generator:
  - div counter runs only in RUN, counting 0..TICK_DIV−1.
  - step = (div == TICK_DIV−1) && !game_over.
  - div clears on entry to RUN and holds in HALT.
- On step, in order:
  - every active slot with col < 15 advances col += 1;
  - a slot at col 15 deactivates (exits);
  - if spawn_cnt == 0, slot next_slot loads active = 1, col = 0, height = lfsr[2:0], size = 3 + lfsr[4:3], and next_slot toggles. A spawn into a slot overrides that slot's exit on the same step;
  - spawn_cnt wraps 0..SPACING−1.
- Entry to RUN (from IDLE or HALT) sets spawn_cnt = 0 and next_slot = slot 1, so the first step spawns into pipe1.
- With SPACING = 8, a slot's exit (step 16k) coincides with its own respawn.
- at_leftN: registered pulse, high exactly one cycle after the step that sets colN to 15.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11, seed 16'hACE1.
  - Advances every clock in every state, including IDLE, so spawn values depend on start timing.
  - Never reaches all-zero.
- HALT: slots, div, spawn_cnt frozen; frames hold the last image.

## Timing
- Reset values:
  - state IDLE, all slots inactive, so frames, heights and sizes are 0;
  - at_left1/2 = 0, running = 0;
  - div = 0, spawn_cnt = 0, next_slot = slot 1, lfsr = 16'hACE1.
- start sampled high in IDLE: RUN next cycle. First step occurs TICK_DIV cycles after RUN entry.
- Frame/geometry latency: outputs change in the cycle after the step edge.
- at_left: same cycle as the frame showing col 15.
- game_over high at a step edge: no shift, HALT next cycle.
- reset mid-RUN, including coincident with a step: reset wins, and all outputs take reset values next cycle.
- start held high continuously: no effect within RUN.

## Structure
- flappy_pkg holds:
  - ROWS/COLS = 16;
  - state enum scroll_state_t {IDLE, RUN, HALT};
  - pipe_slot_t struct {active, col, height, size};
  - LFSR_SEED, MIN_GAP = 3.
- Sub-module lfsr16 (clock, reset, q[15:0]) implements the free-running LFSR.
- Frame decode is a function in the package, reused by the collision stage.

## Test plan
All with TICK_DIV = 4, SPACING = 8. The bench runs a reference LFSR model.
- Reset: hold reset 3 cycles → pipe1 = pipe2 = 0, height/size = 0, running = 0, at_left = 0.
- Start + first step: start pulse → running next cycle; 4 cycles later pipe1 column bit 0 is set on all rows except [h, h+s−1]. h and s match model lfsr[2:0] and 3 + lfsr[4:3] at the step edge; pipe2 = 0.
- Scroll/spawn: after step 8, pipe1 at bit 8 and pipe2 at bit 0. After step 15, at_left1 pulses exactly one cycle with pipe1 at bit 15.
- Exit/respawn coincidence: step 16 → pipe1 back at bit 0 with new model geometry; pipe2 at bit 8; no at_left pulse.
- game_over: assert mid-run coincident with a step → no shift, frames frozen for 100 cycles. Then deassert game_over and pulse start → frames 0 next cycle; pipe1 spawns at bit 0 four cycles later.
- Reset mid-run: assert reset on a step edge at step 10 → all outputs at reset values next cycle; state IDLE.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared types and helpers for the Flappy pipe pipeline: scroller state,
// per-slot pipe geometry and the frame decode reused by the collision stage.
package flappy_pkg;

  localparam int unsigned ROWS = 16;
  localparam int unsigned COLS = 16;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [2:0]  MIN_GAP   = 3'd3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } scroll_state_t;

  typedef struct packed {
    logic       active;
    logic [3:0] col;
    logic [2:0] height;
    logic [2:0] size;
  } pipe_slot_t;

  // Gap spans rows [height, height+size-1]; max top is 7+6-1 = 12, so 4 bits suffice.
  function automatic logic [ROWS-1:0][COLS-1:0] render_slot(input pipe_slot_t s);
    logic [ROWS-1:0][COLS-1:0] f;
    logic [3:0] gap_lo;
    logic [3:0] gap_hi;
    f      = '0;
    gap_lo = {1'b0, s.height};
    gap_hi = {1'b0, s.height} + {1'b0, s.size} - 4'd1;
    if (s.active) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (4'(r) < gap_lo || 4'(r) > gap_hi) begin
          f[r][s.col] = 1'b1;
        end
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/pipe_scroller_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11), right-shifting,
// seeded on reset; never reaches all-zero from a non-zero seed.
module lfsr16
  import flappy_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = {q_q[0] ^ q_q[2] ^ q_q[3] ^ q_q[5], q_q[15:1]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= LFSR_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_scroller.sv
// Spawns and scrolls two pipe obstacles across a 16x16 matrix, one column per
// game step, and renders each slot as a frame plus gap geometry.
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned SPACING  = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      game_over,
  output logic [ROWS-1:0][COLS-1:0] pipe1,
  output logic [ROWS-1:0][COLS-1:0] pipe2,
  output logic [2:0]                height1,
  output logic [2:0]                height2,
  output logic [2:0]                size1,
  output logic [2:0]                size2,
  output logic                      at_left1,
  output logic                      at_left2,
  output logic                      running
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SPC_W = (SPACING > 1) ? $clog2(SPACING) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [SPC_W-1:0] SPC_LAST = SPC_W'(SPACING - 1);

  scroll_state_t    state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [SPC_W-1:0] spawn_q, spawn_d;
  logic             next_slot_q, next_slot_d;
  pipe_slot_t       slot_q [2];
  pipe_slot_t       slot_d [2];
  logic [1:0]       at_left_q, at_left_d;
  logic             step;
  logic [15:0]      lfsr;
  logic             unused_lfsr_hi;

  lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset),
    .q     (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:5];

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    spawn_d     = spawn_q;
    next_slot_d = next_slot_q;
    slot_d      = slot_q;
    at_left_d   = '0;
    step        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          div_d       = '0;
          spawn_d     = '0;
          next_slot_d = 1'b0;
        end
      end
      RUN: begin
        if (game_over) begin
          state_d = HALT;
        end else if (div_q == DIV_LAST) begin
          step  = 1'b1;
          div_d = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      HALT: begin
        if (!game_over && start) begin
          state_d     = RUN;
          div_d       = '0;
          spawn_d     = '0;
          next_slot_d = 1'b0;
          slot_d[0]   = '0;
          slot_d[1]   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Advance/exit first, then let a spawn overwrite its slot so a respawn beats the exit.
    if (step) begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (slot_q[i].active) begin
          if (slot_q[i].col != 4'd15) begin
            slot_d[i].col = slot_q[i].col + 4'd1;
            at_left_d[i]  = (slot_q[i].col == 4'd14);
          end else begin
            slot_d[i].active = 1'b0;
          end
        end
      end
      if (spawn_q == '0) begin
        slot_d[next_slot_q] = '{active: 1'b1,
                                col:    4'd0,
                                height: lfsr[2:0],
                                size:   MIN_GAP + {1'b0, lfsr[4:3]}};
        at_left_d[next_slot_q] = 1'b0;
        next_slot_d = ~next_slot_q;
      end
      spawn_d = (spawn_q == SPC_LAST) ? '0 : spawn_q + SPC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= '0;
      spawn_q     <= '0;
      next_slot_q <= 1'b0;
      slot_q[0]   <= '0;
      slot_q[1]   <= '0;
      at_left_q   <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      spawn_q     <= spawn_d;
      next_slot_q <= next_slot_d;
      slot_q      <= slot_d;
      at_left_q   <= at_left_d;
    end
  end

  assign pipe1    = render_slot(slot_q[0]);
  assign pipe2    = render_slot(slot_q[1]);
  assign height1  = slot_q[0].active ? slot_q[0].height : '0;
  assign height2  = slot_q[1].active ? slot_q[1].height : '0;
  assign size1    = slot_q[0].active ? slot_q[0].size   : '0;
  assign size2    = slot_q[1].active ? slot_q[1].size   : '0;
  assign at_left1 = at_left_q[0];
  assign at_left2 = at_left_q[1];
  assign running  = (state_q == RUN);

endmodule

// File: tb/tb_pipe_scroller.sv
// Scoreboard bench for pipe_scroller: stimulus queues expected outputs tagged
// with a cycle number; a negedge monitor pops and compares them.
module tb_pipe_scroller;

  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct {
    int unsigned        cyc;
    int unsigned        tag;
    logic [15:0][15:0]  p1;
    logic [15:0][15:0]  p2;
    logic [2:0]         h1, s1, h2, s2;
    logic               al1, al2, run;
  } exp_t;

  logic clk = 1'b0;
  logic reset, start, game_over;
  logic [15:0][15:0] pipe1, pipe2;
  logic [2:0] height1, height2, size1, size2;
  logic at_left1, at_left2, running;

  exp_t        sb [$];
  exp_t        e;
  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  int unsigned cyc    = 0;
  logic [15:0] mdl;

  pipe_scroller #(.TICK_DIV(4), .SPACING(8)) dut (
    .clock     (clk),
    .reset     (reset),
    .start     (start),
    .game_over (game_over),
    .pipe1     (pipe1),
    .pipe2     (pipe2),
    .height1   (height1),
    .height2   (height2),
    .size1     (size1),
    .size2     (size2),
    .at_left1  (at_left1),
    .at_left2  (at_left2),
    .running   (running)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: taps 16,14,13,11, right-shift Fibonacci form.
  always @(posedge clk) begin
    if (reset) mdl <= SEED;
    else       mdl <= {mdl[0] ^ mdl[2] ^ mdl[3] ^ mdl[5], mdl[15:1]};
  end

  function automatic logic [15:0][15:0] frame(input int col, input int h, input int s);
    logic [15:0][15:0] f;
    f = '0;
    for (int r = 0; r < 16; r++) begin
      if (r < h || r >= h + s) f[r][col] = 1'b1;
    end
    return f;
  endfunction

  task automatic expect_at(input int unsigned at, input int unsigned tag,
                           input bit a1, input int c1, input logic [15:0] g1,
                           input bit a2, input int c2, input logic [15:0] g2,
                           input bit al1, input bit al2, input bit run);
    exp_t x;
    int hh1, ss1, hh2, ss2;
    hh1 = int'(g1[2:0]); ss1 = 3 + int'(g1[4:3]);
    hh2 = int'(g2[2:0]); ss2 = 3 + int'(g2[4:3]);
    x.cyc = at;
    x.tag = tag;
    x.p1  = a1 ? frame(c1, hh1, ss1) : '0;
    x.p2  = a2 ? frame(c2, hh2, ss2) : '0;
    x.h1  = a1 ? 3'(hh1) : 3'd0;
    x.s1  = a1 ? 3'(ss1) : 3'd0;
    x.h2  = a2 ? 3'(hh2) : 3'd0;
    x.s2  = a2 ? 3'(ss2) : 3'd0;
    x.al1 = al1;
    x.al2 = al2;
    x.run = run;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From a cycle with div = 0, run to just past the next step edge; lf is the
  // LFSR value the DUT samples at that edge.
  task automatic do_step(output logic [15:0] lf);
    repeat (3) tick();
    lf = mdl;
    tick();
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_vec++;
      if (e.cyc < cyc) begin
        n_miss++;
        $display("FAIL vec%0d stale: scheduled cyc %0d, now cyc %0d", e.tag, e.cyc, cyc);
      end else if ({pipe1, pipe2, height1, size1, height2, size2, at_left1, at_left2, running} !==
                   {e.p1, e.p2, e.h1, e.s1, e.h2, e.s2, e.al1, e.al2, e.run}) begin
        n_miss++;
        $display("FAIL vec%0d cyc=%0d got p1=%h p2=%h h1=%0d s1=%0d h2=%0d s2=%0d al=%b%b run=%b want p1=%h p2=%h h1=%0d s1=%0d h2=%0d s2=%0d al=%b%b run=%b",
                 e.tag, cyc, pipe1, pipe2, height1, size1, height2, size2, at_left1, at_left2, running,
                 e.p1, e.p2, e.h1, e.s1, e.h2, e.s2, e.al1, e.al2, e.run);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] g1, g2, lf;
    g1 = '0; g2 = '0; lf = '0;
    reset = 1'b1; start = 1'b0; game_over = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    expect_at(cyc, 0, 0, 0, '0, 0, 0, '0, 0, 0, 0);

    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_at(cyc, 1, 0, 0, '0, 0, 0, '0, 0, 0, 1);

    // Steps 0..17: spawn, scroll, at_left at step 15, exit+respawn at step 16.
    for (int k = 0; k <= 17; k++) begin
      do_step(lf);
      if (k == 0 || k == 16) g1 = lf;
      if (k == 8) g2 = lf;
      expect_at(cyc, 10 + k, 1, (k >= 16) ? k - 16 : k, g1,
                k >= 8, k - 8, g2, k == 15, 0, 1);
      if (k == 15) expect_at(cyc + 1, 100, 1, 15, g1, 1, 7, g2, 0, 0, 1);
    end

    // game_over coincident with step 18: no shift, frozen in HALT.
    repeat (3) tick();
    game_over = 1'b1;
    tick();
    expect_at(cyc, 200, 1, 1, g1, 1, 9, g2, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i % 25 == 24) expect_at(cyc, 201 + i / 25, 1, 1, g1, 1, 9, g2, 0, 0, 0);
    end

    game_over = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_at(cyc, 300, 0, 0, '0, 0, 0, '0, 0, 0, 1);
    do_step(lf);
    g1 = lf;
    expect_at(cyc, 301, 1, 0, g1, 0, 0, '0, 0, 0, 1);

    for (int k = 1; k <= 9; k++) begin
      do_step(lf);
      if (k == 8) g2 = lf;
    end
    expect_at(cyc, 302, 1, 9, g1, 1, 1, g2, 0, 0, 1);

    // Reset landing on the step-10 edge.
    repeat (3) tick();
    reset = 1'b1;
    tick();
    expect_at(cyc, 400, 0, 0, '0, 0, 0, '0, 0, 0, 0);
    reset = 1'b0;
    repeat (8) tick();
    expect_at(cyc, 401, 0, 0, '0, 0, 0, '0, 0, 0, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    do_step(lf);
    expect_at(cyc, 402, 1, 0, lf, 0, 0, '0, 0, 0, 1);

    repeat (3) tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      n_miss++;
      $display("FAIL vec%0d never checked: scheduled cyc %0d, got none, want compare", e.tag, e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
